pwm_multi_ch: RTL and testbench

Parametrised multi-channel PWM generator, next generation of the single-channel 7-bit duty PWM in the TinyTapeout top level. It provides CHANNELS independent duty cycles on one shared timebase with programmable period, clock prescaler and edge- or center-aligned mode. Duty, period, prescale and mode updates are double-buffered and take effect only at a period boundary, so outputs are glitch-free. It sits behind the tt_um top wrapper, which maps ui_in/uio_in onto the write port and drives uo_out from pwm_out.

---
 rtl/pwm_multi_ch.sv | 217 +++++++++++++++++++++
 tb/tb_pwm_multi_ch.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: shared prescaled timebase, edge or center
// alignment, and settings that load only at period boundaries.

module pwm_multi_ch_checker #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRE_W    = 4
) (
  input logic                clk,
  input logic                reset,
  input logic                en,
  input logic [WIDTH-1:0]    cnt,
  input logic [WIDTH-1:0]    period_sh,
  input logic [PRE_W-1:0]    pre_cnt,
  input logic [PRE_W-1:0]    pre_sh,
  input logic [CHANNELS-1:0] pwm_out
);

  cnt_in_range: assert property (@(posedge clk) disable iff (reset)
    cnt <= period_sh);

  pre_in_range: assert property (@(posedge clk) disable iff (reset)
    pre_cnt <= pre_sh);

  off_when_disabled: assert property (@(posedge clk) disable iff (reset)
    !en |=> (pwm_out == {CHANNELS{1'b0}}));

endmodule

module pwm_multi_ch #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRE_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                wr_en,
  input  logic [2:0]          wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  input  logic [WIDTH-1:0]    period,
  input  logic [PRE_W-1:0]    prescale,
  input  logic                center,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(1'b0);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);
  localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(1'b0);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1'b1);

  logic [WIDTH-1:0]    duty_buf_r [CHANNELS];
  logic [WIDTH-1:0]    duty_sh_r  [CHANNELS];
  logic [WIDTH-1:0]    period_sh_r;
  logic [PRE_W-1:0]    pre_sh_r;
  logic                mode_sh_r;
  logic [PRE_W-1:0]    pre_cnt_r;
  logic [WIDTH-1:0]    cnt_r;
  logic                dir_r;
  logic                restart_r;
  logic                new_period_r;

  logic                tick_s;
  logic                boundary_s;
  logic                load_s;
  logic [WIDTH-1:0]    cnt_next_s;
  logic                dir_next_s;
  logic [CHANNELS-1:0] cmp_s;

  // Timebase step: next counter/direction value and boundary detection.
  // Center mode counts 0..P-1 up, then P-1..0 down, so each value below P
  // occurs twice per 2*P-tick period and the waveform mirrors about the
  // boundary. restart_r forces a boundary on the first tick after en returns.
  always_comb begin
    tick_s     = en && (pre_cnt_r == pre_sh_r);
    boundary_s = 1'b0;
    cnt_next_s = cnt_r;
    dir_next_s = dir_r;
    if (!tick_s) begin
      boundary_s = 1'b0;
    end else if (restart_r) begin
      boundary_s = 1'b1;
    end else if (!mode_sh_r) begin
      if (cnt_r == period_sh_r) begin
        boundary_s = 1'b1;
      end else begin
        cnt_next_s = cnt_r + CNT_ONE;
      end
    end else if (period_sh_r == CNT_ZERO) begin
      boundary_s = 1'b1;
    end else if (!dir_r) begin
      if (cnt_r == (period_sh_r - CNT_ONE)) begin
        dir_next_s = 1'b1;
      end else begin
        cnt_next_s = cnt_r + CNT_ONE;
      end
    end else begin
      if (cnt_r == CNT_ZERO) begin
        boundary_s = 1'b1;
      end else begin
        cnt_next_s = cnt_r - CNT_ONE;
      end
    end
    load_s = !en || boundary_s;
  end

  // Per-channel compare against the active (shadowed) duty.
  always_comb begin
    cmp_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      cmp_s[i] = (cnt_r < duty_sh_r[i]);
    end
  end

  // Duty write buffer; indices at or above CHANNELS match no entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_buf_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && (wr_ch == 3'(i))) begin
          duty_buf_r[i] <= wr_duty;
        end else begin
          duty_buf_r[i] <= duty_buf_r[i];
        end
      end
    end
  end

  // Shadow registers: transparent while disabled, otherwise boundary-loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh_r[i] <= CNT_ZERO;
      end
      period_sh_r <= CNT_ZERO;
      pre_sh_r    <= PRE_ZERO;
      mode_sh_r   <= 1'b0;
    end else if (load_s) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh_r[i] <= duty_buf_r[i];
      end
      period_sh_r <= period;
      pre_sh_r    <= prescale;
      mode_sh_r   <= center;
    end else begin
      period_sh_r <= period_sh_r;
      pre_sh_r    <= pre_sh_r;
      mode_sh_r   <= mode_sh_r;
    end
  end

  // Clock prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_r <= PRE_ZERO;
    end else if (!en || tick_s) begin
      pre_cnt_r <= PRE_ZERO;
    end else begin
      pre_cnt_r <= pre_cnt_r + PRE_ONE;
    end
  end

  // Period counter, count direction and restart request.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= CNT_ZERO;
      dir_r     <= 1'b0;
      restart_r <= 1'b0;
    end else if (!en) begin
      cnt_r     <= CNT_ZERO;
      dir_r     <= 1'b0;
      restart_r <= 1'b1;
    end else if (boundary_s) begin
      cnt_r     <= CNT_ZERO;
      dir_r     <= 1'b0;
      restart_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_next_s;
      dir_r     <= dir_next_s;
      restart_r <= restart_r;
    end
  end

  // Registered outputs; period_start is delayed to line up with the first
  // pwm_out sample taken from the new period's counter value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out      <= {CHANNELS{1'b0}};
      new_period_r <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= en ? cmp_s : {CHANNELS{1'b0}};
      new_period_r <= boundary_s;
      period_start <= new_period_r && en;
    end
  end

  pwm_multi_ch_checker #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .PRE_W    (PRE_W)
  ) u_checker (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cnt       (cnt_r),
    .period_sh (period_sh_r),
    .pre_cnt   (pre_cnt_r),
    .pre_sh    (pre_sh_r),
    .pwm_out   (pwm_out)
  );

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: per-period measurements against a vector table,
// hand-written buffering/enable/reset sequences, and a random run checked
// every clock against a position-based reference model.

module tb_pwm_multi_ch;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_ch = 3'd0;
  logic [7:0]    wr_duty = 8'd0;
  logic [7:0]    period = 8'd0;
  logic [3:0]    prescale = 4'd0;
  logic          center = 1'b0;
  logic [CH-1:0] pwm_out;
  logic          period_start;

  pwm_multi_ch #(.CHANNELS(CH), .WIDTH(8), .PRE_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_duty      (wr_duty),
    .period       (period),
    .prescale     (prescale),
    .center       (center),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: position inside the period rather than an up/down counter.
  int          m_buf [CH];
  int          m_sh  [CH];
  int          m_per, m_pre, m_mode, m_prediv, m_pos;
  bit          m_restart, m_first, m_ps;
  logic [CH-1:0] m_pwm;

  int meas_len;
  int meas_high [CH];
  bit meas_wave [1024];

  typedef struct {
    int per;
    int pre;
    bit ctr;
    int duty [CH];
    int len;
    int high [CH];
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_cnt(input int pos);
    if (m_mode == 0) return pos;
    if (m_per == 0) return 0;
    return (pos < m_per) ? pos : (2 * m_per - 1 - pos);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_buf[i] = 0;
      m_sh[i]  = 0;
    end
    m_per = 0; m_pre = 0; m_mode = 0; m_prediv = 0; m_pos = 0;
    m_restart = 1'b0; m_first = 1'b0; m_ps = 1'b0; m_pwm = '0;
  endtask

  // One clock: predict from pre-edge inputs, clock, then compare.
  task automatic step();
    bit r, tick, bnd, n_restart, n_first, n_ps;
    int len, c, n_per, n_pre, n_mode, n_prediv, n_pos;
    int n_buf [CH];
    int n_sh  [CH];
    logic [CH-1:0] n_pwm;
    r = reset;
    n_buf = m_buf; n_sh = m_sh;
    n_per = m_per; n_pre = m_pre; n_mode = m_mode; n_pos = m_pos;
    n_restart = m_restart;
    tick = en && (m_prediv == m_pre);
    if (m_mode == 1) len = (m_per == 0) ? 1 : 2 * m_per;
    else len = m_per + 1;
    c = model_cnt(m_pos);
    bnd = tick && (m_restart || (m_pos == len - 1));
    for (int i = 0; i < CH; i++) n_pwm[i] = en && (c < m_sh[i]);
    n_ps = m_first && en;
    n_first = bnd;
    n_prediv = (!en || tick) ? 0 : m_prediv + 1;
    if (!en || bnd) begin
      n_sh = m_buf;
      n_per = int'(period); n_pre = int'(prescale); n_mode = int'(center);
      n_pos = 0;
      n_restart = !en;
    end else if (tick) begin
      n_pos = m_pos + 1;
    end
    if (wr_en && (int'(wr_ch) < CH)) n_buf[int'(wr_ch)] = int'(wr_duty);
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      m_buf = n_buf; m_sh = n_sh;
      m_per = n_per; m_pre = n_pre; m_mode = n_mode; m_prediv = n_prediv;
      m_pos = n_pos; m_restart = n_restart; m_first = n_first;
      m_ps = n_ps; m_pwm = n_pwm;
    end
    chk("model", {27'd0, period_start, pwm_out}, {27'd0, m_ps, m_pwm});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    chk("reset_state", {27'd0, period_start, pwm_out}, 32'd0);
    reset = 1'b0;
  endtask

  // Measure one period starting at a period_start sample; optionally inject
  // a write after sample wr_at.
  task automatic measure(input int wr_at, input int wr_c, input int wr_d);
    int k;
    k = 0;
    while (period_start !== 1'b1 && k < 3000) begin
      step();
      k++;
    end
    if (period_start !== 1'b1) begin
      chk("wait_period_start", 32'd0, 32'd1);
      return;
    end
    meas_len = 0;
    for (int i = 0; i < CH; i++) meas_high[i] = 0;
    do begin
      for (int i = 0; i < CH; i++) meas_high[i] += int'(pwm_out[i]);
      if (meas_len < 1024) meas_wave[meas_len] = pwm_out[0];
      if (meas_len == wr_at) begin
        wr_en = 1'b1; wr_ch = wr_c[2:0]; wr_duty = wr_d[7:0];
      end
      meas_len++;
      step();
      wr_en = 1'b0;
    end while (period_start !== 1'b1 && meas_len < 3000);
    if (period_start !== 1'b1) chk("period_end_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_vec(input int idx, input int per, input int pre, input bit ctr,
                         input int d0, input int d1, input int d2, input int d3,
                         input int len, input int h0, input int h1, input int h2, input int h3);
    tbl[idx].per = per; tbl[idx].pre = pre; tbl[idx].ctr = ctr; tbl[idx].len = len;
    tbl[idx].duty[0] = d0; tbl[idx].duty[1] = d1; tbl[idx].duty[2] = d2; tbl[idx].duty[3] = d3;
    tbl[idx].high[0] = h0; tbl[idx].high[1] = h1; tbl[idx].high[2] = h2; tbl[idx].high[3] = h3;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    bit sym, acc;
    model_reset();

    //      idx per pre ctr  duties           len  high counts per channel
    set_vec(0,  9,  0,  0,   0, 3, 10, 255,   10,  0, 3, 10, 10);
    set_vec(1,  4,  2,  0,   2, 0,  5,   1,   15,  6, 0, 15,  3);
    set_vec(2,  5,  0,  1,   2, 0,  6,   5,   10,  4, 0, 10, 10);
    set_vec(3,  3,  1,  1,   1, 2,  3,   0,   12,  4, 8, 12,  0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      period = 8'(tbl[v].per); prescale = 4'(tbl[v].pre); center = tbl[v].ctr;
      en = 1'b1;
      for (int j = 0; j < CH; j++) begin
        wr_en = 1'b1; wr_ch = 3'(j); wr_duty = 8'(tbl[v].duty[j]);
        step();
      end
      wr_en = 1'b0;
      measure(-1, 0, 0);
      measure(-1, 0, 0);
      chk($sformatf("vec%0d_len", v), meas_len, tbl[v].len);
      for (int j = 0; j < CH; j++)
        chk($sformatf("vec%0d_high_ch%0d", v, j), meas_high[j], tbl[v].high[j]);
      if (tbl[v].ctr) begin
        sym = 1'b1;
        for (int j = 0; j < meas_len; j++)
          if (meas_wave[j] != meas_wave[meas_len - 1 - j]) sym = 1'b0;
        chk($sformatf("vec%0d_symmetric", v), sym, 1);
      end
    end

    // Double buffering: mid-period write, then a write in the boundary cycle.
    do_reset();
    period = 8'd9; prescale = 4'd0; center = 1'b0; en = 1'b1;
    wr_en = 1'b1; wr_ch = 3'd1; wr_duty = 8'd3;
    step();
    wr_en = 1'b0;
    measure(-1, 0, 0);
    measure(-1, 0, 0);
    chk("db_initial", meas_high[1], 3);
    measure(1, 1, 7);
    chk("db_old_persists", meas_high[1], 3);
    measure(-1, 0, 0);
    chk("db_new_duty", meas_high[1], 7);
    measure(8, 1, 2);
    chk("db_bnd_cycle_period", meas_high[1], 7);
    measure(-1, 0, 0);
    chk("db_bnd_write_not_captured", meas_high[1], 7);
    measure(-1, 0, 0);
    chk("db_bnd_write_later", meas_high[1], 2);

    // Out-of-range channel write leaves every buffer alone.
    wr_en = 1'b1; wr_ch = 3'd5; wr_duty = 8'd200;
    step();
    wr_en = 1'b0;
    measure(-1, 0, 0);
    measure(-1, 0, 0);
    chk("badch_len", meas_len, 10);
    chk("badch_ch0", meas_high[0], 0);
    chk("badch_ch1", meas_high[1], 2);
    chk("badch_ch2", meas_high[2], 0);
    chk("badch_ch3", meas_high[3], 0);

    // Enable dropped during a high pulse, then restored.
    chk("en_pre_high", pwm_out[1], 1);
    en = 1'b0;
    step();
    chk("en_off_pwm", pwm_out, 0);
    acc = 1'b0;
    repeat (5) begin
      step();
      acc = acc | (|pwm_out) | period_start;
    end
    chk("en_off_hold", acc, 0);
    en = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (period_start !== 1'b1 && n < 20);
    chk("reenable_latency", n, 2);
    measure(-1, 0, 0);
    chk("reenable_len", meas_len, 10);
    chk("reenable_ch1", meas_high[1], 2);

    // Reset during a high pulse discards buffered duties.
    chk("rst_pre_high", pwm_out[1], 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_outputs", {27'd0, period_start, pwm_out}, 32'd0);
    acc = 1'b0;
    repeat (40) begin
      step();
      acc = acc | (|pwm_out);
    end
    chk("rst_quiet", acc, 0);

    // Randomized run, checked every clock against the model.
    do_reset();
    period = 8'd6; prescale = 4'd1; center = 1'b0; en = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_ch = 3'($urandom_range(0, 7));
      wr_duty = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 14));
      if ($urandom_range(0, 149) == 0) period = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 149) == 0) prescale = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 249) == 0) center = ~center;
      if (en && $urandom_range(0, 199) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
      reset = ($urandom_range(0, 1499) == 0);
      step();
    end
    reset = 1'b0;
    wr_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
